avmm_button_led_pio: RTL and testbench
======================================

Name: avmm_button_led_pio

Overview:
- Parametrised Avalon-MM slave peripheral that replaces the fixed 2-button / 10-LED PIO pair in the system.
- Button path: per-channel 2-FF synchroniser, then debouncer, then edge capture with maskable interrupt.
- LED path: a register bank that drives the LED export.
- Lives in the main clk_clk domain on the CPU data master's bus.

Parameters:
- N_BTN, 2, number of button inputs (1..32).
- N_LED, 10, number of LED outputs (1..32).
- DEBOUNCE_CYCLES, 50000, input must be stable for this many consecutive clk_clk cycles before it is accepted (>=2).
- BTN_ACTIVE_LOW, 1, 1 = pin low means pressed; internal logic uses pressed=1.
- EDGE_MODE, 0, edge capture trigger: 0 = press, 1 = release, 2 = both.

Ports:
- clk_clk  in  1  system clock.
- reset_reset  in  1  reset; synchronous, active-high.
- avs_address  in  3  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data; fixed read latency of 1.
- irq  out  1  level interrupt.
- button_export  in  N_BTN  raw, asynchronous button pins.
- led_export  out  N_LED  LED drive, active-high.

Behaviour:
- Reset (reset_reset=1 at clk edge):
  - Outputs: avs_readdata=0, irq=0, led_export=0.
  - Synchroniser flops = inactive pin level.
  - Debounced state=0; debounce counters=0; EDGE=0; MASK=0; LED=0.
  - Reset mid-debounce discards the partial count.
- Synchroniser: 2 flops per channel. Polarity inverted after the synchroniser when BTN_ACTIVE_LOW=1.
- Debounce, per channel, with counter width clog2(DEBOUNCE_CYCLES):
  - sync == stable: counter cleared to 0.
  - sync != stable: counter increments.
  - When counter == DEBOUNCE_CYCLES-1 and sync still differs: stable <= sync and counter <= 0 on that edge.
  - Net effect: stable changes exactly DEBOUNCE_CYCLES cycles after the first differing sync sample.
  - Any sample equal to stable before then restarts the window. Counter never wraps.
- Edge detect, per channel: event when stable rises (mode 0), falls (mode 1), or either (mode 2). The event sets EDGE[i] on the same edge on which stable updates.
- Register map (word addresses):
  - 0 DATA: RO, bits [N_BTN-1:0] = stable. Writes ignored.
  - 1 EDGE: read returns captured edges. Write-1-to-clear per bit. If a clear and a new event hit the same bit in the same cycle, the event wins (bit stays 1).
  - 2 MASK: RW, [N_BTN-1:0].
  - 3 LED: RW, [N_LED-1:0]; drives led_export combinationally from the register (one cycle after the write).
  - 4 PWM: see Optional Feature.
  - 5..7: read 0, writes ignored.
- Register bits above the channel width read 0 and ignore writes.
- Read: avs_readdata is registered. It is valid the cycle after avs_read=1 and holds until the next read. EDGE reads have no side effect.
- Simultaneous avs_read and avs_write: both are performed. Read returns the pre-write value.
- irq: registered, irq <= |(EDGE & MASK). It therefore asserts 1 cycle after the bit sets and deasserts 1 cycle after the clear or the mask write.

Optional Feature:
- Macro: AVMM_BUTTON_LED_PIO_PWM_EN.
- Defined:
  - Address 4 = PWM duty, RW [7:0], reset 0xFF.
  - Free-running 8-bit counter pwm_cnt, reset 0, increments every cycle and wraps 255->0.
  - led_export = LED & {N_LED{pwm_cnt < duty}}, registered (1 additional cycle).
  - duty=0 gives LEDs always off; duty=0xFF gives on 255 of 256 cycles.
- Not defined:
  - Address 4 reads 0, writes ignored.
  - led_export = LED with no gating.
  - No counter logic is synthesised.

Test Plan:
- Reset, then read addr 0..7 -> all return 0x00000000; irq=0; led_export=0.
- DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1: drive button_export[0] 1->0 and hold -> DATA reads 0x1 exactly 2+4 cycles after the pin change; EDGE[0]=1 on that same cycle. With MASK=0x1, irq=1 one cycle later.
- Same setup, pin low for 3 cycles, back high, then low for 3 more -> DATA stays 0, EDGE stays 0 (counter restarted; bounce rejected).
- EDGE=0x1, MASK=0x1: write 0x1 to addr 1 -> EDGE reads 0, irq drops 1 cycle after the write. Repeat with a new press event landing in the write cycle -> EDGE stays 0x1, irq stays 1.
- Write 0x2A5 to addr 3 -> led_export=0x2A5 the next cycle; readback addr 3 = 0x2A5. Write 0xFFFFFFFF -> readback 0x3FF.
- With AVMM_BUTTON_LED_PIO_PWM_EN: LED=0x3FF, duty=0x40 -> led_export high for exactly 64 of every 256 cycles. duty=0 -> led_export constantly 0.

Source files
------------

// File: rtl/avmm_button_led_pio.sv
// Avalon-MM button/LED PIO: synchronised, debounced buttons with edge capture and irq, LED register.
// Define AVMM_BUTTON_LED_PIO_PWM_EN to add an 8-bit PWM duty register gating the LED outputs.
module avmm_button_led_pio #(
    parameter int unsigned N_BTN           = 2,
    parameter int unsigned N_LED           = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned BTN_ACTIVE_LOW  = 1,
    parameter int unsigned EDGE_MODE       = 0
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq,
    input  logic [N_BTN-1:0] button_export,
    output logic [N_LED-1:0] led_export
);
    localparam int unsigned      CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]    CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
    // Idle pin level; also the XOR mask that turns the synchronised pin into pressed=1.
    localparam logic [N_BTN-1:0] SYNC_RST = {N_BTN{BTN_ACTIVE_LOW != 0}};

    logic [N_BTN-1:0]         sync1_q, sync2_q, pressed;
    logic [N_BTN-1:0]         stable_q, stable_d;
    logic [N_BTN-1:0][CW-1:0] cnt_q, cnt_d;
    logic [N_BTN-1:0]         rise, fall, evt;
    logic [N_BTN-1:0]         edge_q, edge_d, mask_q;
    logic [N_LED-1:0]         led_q;
    logic [31:0]              readdata_q, rdata_d;
    logic                     irq_q;
    logic                     wr_edge, wr_mask, wr_led;
    logic                     unused_wdata;

    assign unused_wdata = ^avs_writedata;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q <= SYNC_RST;
            sync2_q <= SYNC_RST;
        end else begin
            sync1_q <= button_export;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = sync2_q ^ SYNC_RST;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < int'(N_BTN); i++) begin
            if (pressed[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = pressed[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        rise = stable_d & ~stable_q;
        fall = ~stable_d & stable_q;
        if (EDGE_MODE == 0) begin
            evt = rise;
        end else if (EDGE_MODE == 1) begin
            evt = fall;
        end else begin
            evt = rise | fall;
        end
    end

    assign wr_edge = avs_write && (avs_address == 3'd1);
    assign wr_mask = avs_write && (avs_address == 3'd2);
    assign wr_led  = avs_write && (avs_address == 3'd3);

    // A new event on the same cycle as a W1C keeps the bit set.
    assign edge_d = (edge_q & ~(wr_edge ? avs_writedata[N_BTN-1:0] : '0)) | evt;

`ifdef AVMM_BUTTON_LED_PIO_PWM_EN
    logic [7:0]       duty_q, pwm_cnt_q;
    logic [N_LED-1:0] led_out_q;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            duty_q    <= 8'hFF;
            pwm_cnt_q <= 8'h00;
            led_out_q <= '0;
        end else begin
            if (avs_write && (avs_address == 3'd4)) begin
                duty_q <= avs_writedata[7:0];
            end
            pwm_cnt_q <= pwm_cnt_q + 8'h01;
            led_out_q <= led_q & {N_LED{pwm_cnt_q < duty_q}};
        end
    end

    assign led_export = led_out_q;
`else
    assign led_export = led_q;
`endif

    always_comb begin
        rdata_d = '0;
        case (avs_address)
            3'd0: rdata_d[N_BTN-1:0] = stable_q;
            3'd1: rdata_d[N_BTN-1:0] = edge_q;
            3'd2: rdata_d[N_BTN-1:0] = mask_q;
            3'd3: rdata_d[N_LED-1:0] = led_q;
`ifdef AVMM_BUTTON_LED_PIO_PWM_EN
            3'd4: rdata_d[7:0] = duty_q;
`endif
            default: rdata_d = '0;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            stable_q   <= '0;
            cnt_q      <= '0;
            edge_q     <= '0;
            mask_q     <= '0;
            led_q      <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            edge_q   <= edge_d;
            if (wr_mask) begin
                mask_q <= avs_writedata[N_BTN-1:0];
            end
            if (wr_led) begin
                led_q <= avs_writedata[N_LED-1:0];
            end
            if (avs_read) begin
                readdata_q <= rdata_d;
            end
            irq_q <= |(edge_q & mask_q);
        end
    end

    assign avs_readdata = readdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_avmm_button_led_pio.sv
// Directed bench for avmm_button_led_pio with DEBOUNCE_CYCLES=4; read results go through a scoreboard.
module tb_avmm_button_led_pio;
    localparam int unsigned N_BTN = 2;
    localparam int unsigned N_LED = 10;

    logic             clk_clk = 1'b0;
    logic             reset_reset = 1'b1;
    logic [2:0]       avs_address = '0;
    logic             avs_read = 1'b0;
    logic             avs_write = 1'b0;
    logic [31:0]      avs_writedata = '0;
    logic [31:0]      avs_readdata;
    logic             irq;
    logic [N_BTN-1:0] button_export = '1;
    logic [N_LED-1:0] led_export;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    avmm_button_led_pio #(
        .N_BTN(N_BTN),
        .N_LED(N_LED),
        .DEBOUNCE_CYCLES(4),
        .BTN_ACTIVE_LOW(1),
        .EDGE_MODE(0)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset(reset_reset),
        .avs_address(avs_address),
        .avs_read(avs_read),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_readdata(avs_readdata),
        .irq(irq),
        .button_export(button_export),
        .led_export(led_export)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // All tasks start and end just after a falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_clk);
            @(negedge clk_clk);
        end
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
        avs_address = a;
        avs_read    = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick(1);
        avs_read = 1'b0;
        chk(tag_q.pop_front(), avs_readdata, exp_q.pop_front());
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick(1);
        avs_write = 1'b0;
    endtask

    task automatic rdwr(input logic [2:0] a, input logic [31:0] d, input logic [31:0] exp,
                        input string tag);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        avs_read      = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        tick(1);
        avs_write = 1'b0;
        avs_read  = 1'b0;
        chk(tag_q.pop_front(), avs_readdata, exp_q.pop_front());
    endtask

    initial begin
        int hi;
        int bad;
        logic [31:0] exp_rst;
        @(negedge clk_clk);
        tick(3);
        reset_reset = 1'b0;

        chk("reset_irq", {31'b0, irq}, 32'h0);
        chk("reset_led", {22'b0, led_export}, 32'h0);
        for (int a = 0; a < 8; a++) begin
            exp_rst = 32'h0;
`ifdef AVMM_BUTTON_LED_PIO_PWM_EN
            if (a == 4) exp_rst = 32'hFF;
`endif
            rd(3'(a), exp_rst, $sformatf("reset_rd%0d", a));
        end

        // Bounce: 3 low samples, 1 high, 3 low never reach the 4-cycle window.
        button_export[0] = 1'b0;
        for (int i = 0; i < 3; i++) rd(3'd0, 32'h0, "bounce_data");
        button_export[0] = 1'b1;
        rd(3'd0, 32'h0, "bounce_data");
        button_export[0] = 1'b0;
        for (int i = 0; i < 3; i++) rd(3'd0, 32'h0, "bounce_data");
        button_export[0] = 1'b1;
        for (int i = 0; i < 6; i++) rd(3'd0, 32'h0, "bounce_data_after");
        rd(3'd1, 32'h0, "bounce_edge");

        wr(3'd2, 32'h1);

        // Press: stable rises on the 6th edge after the pin change.
        button_export[0] = 1'b0;
        for (int i = 0; i < 5; i++) rd(3'd0, 32'h0, "press_data_early");
        rd(3'd1, 32'h0, "press_edge_early");
        chk("press_irq_early", {31'b0, irq}, 32'h0);
        rd(3'd0, 32'h1, "press_data");
        chk("press_irq", {31'b0, irq}, 32'h1);
        rd(3'd1, 32'h1, "press_edge");

        // Release makes no event in press mode.
        button_export[0] = 1'b1;
        tick(8);
        rd(3'd1, 32'h1, "release_edge");
        rd(3'd0, 32'h0, "release_data");

        // W1C on the same edge as a new press: the event wins.
        button_export[0] = 1'b0;
        tick(5);
        wr(3'd1, 32'h1);
        chk("collide_irq0", {31'b0, irq}, 32'h1);
        tick(1);
        chk("collide_irq1", {31'b0, irq}, 32'h1);
        rd(3'd1, 32'h1, "collide_edge");

        wr(3'd1, 32'h1);
        chk("clear_irq_same", {31'b0, irq}, 32'h1);
        tick(1);
        chk("clear_irq_next", {31'b0, irq}, 32'h0);
        rd(3'd1, 32'h0, "clear_edge");

        rdwr(3'd2, 32'hFFFF_FFFF, 32'h1, "mask_rdwr_old");
        rd(3'd2, 32'h3, "mask_width");
        wr(3'd2, 32'h0);
        rd(3'd2, 32'h0, "mask_zero");

        wr(3'd0, 32'hFFFF_FFFF);
        rd(3'd0, 32'h1, "data_ro");
        tick(2);
        chk("readdata_hold", avs_readdata, 32'h1);
        wr(3'd5, 32'hFFFF_FFFF);
        rd(3'd5, 32'h0, "addr5");
        rd(3'd7, 32'h0, "addr7");

`ifndef AVMM_BUTTON_LED_PIO_PWM_EN
        chk("led_before", {22'b0, led_export}, 32'h0);
        wr(3'd3, 32'h2A5);
        chk("led_2a5", {22'b0, led_export}, 32'h2A5);
        rd(3'd3, 32'h2A5, "led_rd_2a5");
        wr(3'd3, 32'hFFFF_FFFF);
        chk("led_3ff", {22'b0, led_export}, 32'h3FF);
        rd(3'd3, 32'h3FF, "led_rd_3ff");
        wr(3'd4, 32'hFFFF_FFFF);
        rd(3'd4, 32'h0, "pwm_absent");
`else
        wr(3'd3, 32'hFFFF_FFFF);
        rd(3'd3, 32'h3FF, "led_rd_3ff");
        wr(3'd4, 32'h40);
        rd(3'd4, 32'h40, "duty_rd");
        hi = 0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            tick(1);
            if (led_export == 10'h3FF) hi++;
            else if (led_export != 10'h0) bad++;
        end
        chk("pwm_high_64", 32'(hi), 32'd64);
        chk("pwm_partial", 32'(bad), 32'd0);
        wr(3'd4, 32'h0);
        tick(1);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            tick(1);
            if (led_export != 10'h0) hi++;
        end
        chk("pwm_duty0", 32'(hi), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
